// File: rtl/fsm_test_ctrl_pkg.sv
// Shared types and constants for the fsm_test_ctrl scenario controller.
// Optional input debounce filter is selected with FSM_TEST_DEBOUNCE_EN.
package fsm_test_pkg;

  localparam int CNT_W   = 32;
  localparam int STATE_W = 3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 10;
  localparam int unsigned DEF_DELAY_CYCLES    = 400_000;
  localparam int unsigned DEF_PULSE_CYCLES    = 4;
  localparam int unsigned DEF_HOLDOFF_CYCLES  = 1_280_000;
  localparam int unsigned DEF_MAX_TRIGGERS    = 0;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_TRIGGER = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Down-counter reload: a phase of N cycles counts N-1..0; zero-length
  // phases still occupy one cycle.
  function automatic logic [CNT_W-1:0] load_val(input int unsigned cycles);
    return (cycles == 0) ? '0 : CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/fsm_test_ctrl_if.sv
// Front-end/detector signal bundle for fsm_test_ctrl; master drives the
// timing inputs, slave is the controller.
interface fsm_test_ctrl_if;
  import fsm_test_pkg::*;

  logic               start_signal;
  logic               fg_signal;
  logic               output_trigger;
  logic [STATE_W-1:0] scenario_state;
  logic [CNT_W-1:0]   counter_;

  modport master (
    output start_signal,
    output fg_signal,
    input  output_trigger,
    input  scenario_state,
    input  counter_
  );

  modport slave (
    input  start_signal,
    input  fg_signal,
    output output_trigger,
    output scenario_state,
    output counter_
  );

endinterface

// File: rtl/fsm_test_ctrl_debounce.sv
// 2-flop synchronizer followed by a stable-count filter when
// FSM_TEST_DEBOUNCE_EN is defined; otherwise the synchronizer output is used.
module fsm_debounce
  import fsm_test_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_i,
  output logic sig_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef FSM_TEST_DEBOUNCE_EN
  localparam int unsigned FILT_N = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int          FILT_W = $clog2(FILT_N + 1);

  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic              filt_q, filt_d;

  // Any cycle agreeing with the filtered value restarts the stability count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == FILT_W'(FILT_N - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign sig_o = filt_q;
`else
  assign sig_o = sync2_q;
`endif

endmodule

// File: rtl/fsm_test_ctrl.sv
// Scenario controller: arms on start, fires one delayed trigger pulse per
// qualified fast-gate rise, then holds off. Input filtering via FSM_TEST_DEBOUNCE_EN.
module fsm_test_ctrl
  import fsm_test_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DELAY_CYCLES    = DEF_DELAY_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
  parameter int unsigned MAX_TRIGGERS    = DEF_MAX_TRIGGERS
) (
  input logic           clock,
  input logic           reset,
  fsm_test_ctrl_if.slave bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic start_f;
  logic fg_f;
  logic fg_prev_q;
  logic fg_rise;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_q;

  fsm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_deb (
    .clock (clock),
    .reset (reset),
    .sig_i (bus.start_signal),
    .sig_o (start_f)
  );

  fsm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fg_deb (
    .clock (clock),
    .reset (reset),
    .sig_i (bus.fg_signal),
    .sig_o (fg_f)
  );

  assign fg_rise = fg_f & ~fg_prev_q;

  // Single down-counter is shared by DELAY, TRIGGER and HOLDOFF phases.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_f) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (!start_f) begin
          state_d = ST_IDLE;
        end else if (fg_rise) begin
          state_d = ST_DELAY;
          tmr_d   = load_val(DELAY_CYCLES);
        end
      end
      ST_DELAY: begin
        if (!start_f) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          state_d = ST_TRIGGER;
          tmr_d   = load_val(PULSE_CYCLES);
          cnt_d   = sat_inc(cnt_q);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_TRIGGER: begin
        if (tmr_q == '0) begin
          state_d = ST_HOLDOFF;
          tmr_d   = load_val(HOLDOFF_CYCLES);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (tmr_q == '0) begin
          if ((MAX_TRIGGERS != 0) && (cnt_q == CNT_W'(MAX_TRIGGERS))) begin
            state_d = ST_DONE;
          end else if (start_f) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (!start_f) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Trigger is registered from the next state so it aligns with TRIGGER.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      trig_q    <= 1'b0;
      fg_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      trig_q    <= (state_d == ST_TRIGGER);
      fg_prev_q <= fg_f;
    end
  end

  assign bus.output_trigger = trig_q;
  assign bus.scenario_state = state_q;
  assign bus.counter_       = cnt_q;

endmodule

// File: tb/tb_fsm_test_ctrl.sv
// Directed bench for fsm_test_ctrl with short timing parameters and MAX_TRIGGERS=3.
module tb_fsm_test_ctrl;

  localparam int unsigned DEB     = 10;
  localparam int unsigned DLY     = 20;
  localparam int unsigned PULSE   = 4;
  localparam int unsigned HOLDOFF = 50;
  localparam int unsigned MAXT    = 3;
`ifdef FSM_TEST_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic clock = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  fsm_test_ctrl_if bus ();

  fsm_test_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .DELAY_CYCLES    (DLY),
    .PULSE_CYCLES    (PULSE),
    .HOLDOFF_CYCLES  (HOLDOFF),
    .MAX_TRIGGERS    (MAXT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int highs;
    int found;
    logic prev;

    // Reset held low with inputs active: everything stays at zero.
    reset = 1'b0;
    bus.start_signal = 1'b1;
    bus.fg_signal    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("rst_trig",  32'(bus.output_trigger), 0);
      check("rst_state", 32'(bus.scenario_state), 0);
      check("rst_cnt",   bus.counter_, 0);
    end
    reset = 1'b1;
    bus.start_signal = 1'b0;
    bus.fg_signal    = 1'b0;
    step(LAT + 2);
    check("idle_state", 32'(bus.scenario_state), 0);

    // Single trigger.
    bus.start_signal = 1'b1;
    step(LAT - 1);
    check("arm_lat_state", 32'(bus.scenario_state), 0);
    step(1);
    check("armed_state", 32'(bus.scenario_state), 1);
    check("armed_cnt",   bus.counter_, 0);
    bus.fg_signal = 1'b1;
    step(LAT - 1);
    check("pre_delay_state", 32'(bus.scenario_state), 1);
    step(1);
    check("delay_state", 32'(bus.scenario_state), 2);
    step(DLY - 1);
    check("delay_end_state", 32'(bus.scenario_state), 2);
    check("delay_end_trig",  32'(bus.output_trigger), 0);
    step(1);
    check("trig_state", 32'(bus.scenario_state), 3);
    check("trig_rise",  32'(bus.output_trigger), 1);
    check("trig_cnt",   bus.counter_, 1);
    for (int i = 0; i < PULSE - 1; i++) begin
      step(1);
      check("trig_width", 32'(bus.output_trigger), 1);
    end
    step(1);
    check("holdoff_state", 32'(bus.scenario_state), 4);
    check("holdoff_trig",  32'(bus.output_trigger), 0);

    // Second fg rise 10 cycles into hold-off is masked.
    bus.fg_signal = 1'b0;
    step(10);
    bus.fg_signal = 1'b1;
    step(HOLDOFF - 11);
    check("holdoff_end_state", 32'(bus.scenario_state), 4);
    step(1);
    check("rearm_state", 32'(bus.scenario_state), 1);
    check("rearm_cnt",   bus.counter_, 1);
    step(20);
    check("mask_state", 32'(bus.scenario_state), 1);
    check("mask_cnt",   bus.counter_, 1);
    check("mask_trig",  32'(bus.output_trigger), 0);

    // Bouncing fast gate yields exactly one trigger.
    bus.fg_signal = 1'b0;
    step(LAT + 2);
    check("bounce_pre_state", 32'(bus.scenario_state), 1);
    bus.fg_signal = 1'b1;
    step(3);
    bus.fg_signal = 1'b0;
    step(3);
    bus.fg_signal = 1'b1;
    pulses = 0;
    highs  = 0;
    prev   = bus.output_trigger;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (bus.output_trigger && !prev) pulses++;
      if (bus.output_trigger) highs++;
      prev = bus.output_trigger;
    end
    check("bounce_pulses", pulses, 1);
    check("bounce_width",  highs, PULSE);
    check("bounce_cnt",    bus.counter_, 2);
    check("bounce_state",  32'(bus.scenario_state), 1);

    // Start drops during DELAY: abort without trigger.
    bus.fg_signal = 1'b0;
    step(LAT + 2);
    bus.fg_signal = 1'b1;
    step(LAT);
    check("abort_delay_state", 32'(bus.scenario_state), 2);
    bus.start_signal = 1'b0;
    step(LAT);
    check("abort_state", 32'(bus.scenario_state), 0);
    check("abort_cnt",   bus.counter_, 2);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (bus.output_trigger) highs++;
    end
    check("abort_no_trig", highs, 0);

    // Trigger limit: 5 fg periods, 3 triggers, then DONE.
    bus.start_signal = 1'b1;
    step(LAT);
    check("lim_arm_state", 32'(bus.scenario_state), 1);
    check("lim_arm_cnt",   bus.counter_, 0);
    pulses = 0;
    prev   = bus.output_trigger;
    for (int p = 0; p < 5; p++) begin
      bus.fg_signal = 1'b0;
      step(20);
      bus.fg_signal = 1'b1;
      for (int i = 0; i < 100; i++) begin
        step(1);
        if (bus.output_trigger && !prev) pulses++;
        prev = bus.output_trigger;
      end
    end
    check("lim_pulses", pulses, MAXT);
    check("lim_state",  32'(bus.scenario_state), 5);
    check("lim_cnt",    bus.counter_, MAXT);
    bus.start_signal = 1'b0;
    step(LAT);
    check("done_idle_state", 32'(bus.scenario_state), 0);
    check("done_idle_cnt",   bus.counter_, MAXT);
    bus.start_signal = 1'b1;
    step(LAT);
    check("lim_rearm_state", 32'(bus.scenario_state), 1);
    check("lim_rearm_cnt",   bus.counter_, 0);

    // Reset asserted mid-pulse clears everything on the next edge.
    bus.fg_signal = 1'b0;
    step(20);
    bus.fg_signal = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step(1);
      if (bus.output_trigger) found = 1;
    end
    check("midpulse_reached", found, 1);
    reset = 1'b0;
    step(1);
    check("midrst_trig",  32'(bus.output_trigger), 0);
    check("midrst_state", 32'(bus.scenario_state), 0);
    check("midrst_cnt",   bus.counter_, 0);
    reset = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
